mem_line_master: RTL and testbench

- Initiator side of the 128-bit slow-memory line protocol (mem_read/mem_write/mem_addr[31:4]/mem_wdata/mem_rdata/mem_ready).
- Sits between a cache controller (D or I) and slow_memory. It turns one cache-side miss request (fill only, write only, or dirty-evict-then-fill) into a correctly sequenced series of bus transactions.
- Returns the fill line to the cache with a single-cycle valid pulse.

---
 rtl/mem_line_master.sv | 143 ++++++++++++++
 tb/tb_mem_line_master.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_master.sv
// Initiator for the 128-bit slow-memory line bus: turns one cache miss request
// into write-back / gap / read transactions. Optional watchdog: MEM_TIMEOUT_EN.
module mem_line_master #(
    parameter int ADDR_W      = 28,
    parameter int LINE_W      = 128,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wb,
    input  logic              req_fill,
    input  logic [ADDR_W-1:0] req_wb_addr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LINE_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [LINE_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [2:0] {S_IDLE, S_WB, S_GAP, S_RD, S_DONE} state_t;

    localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYC - 1);

    state_t            state, next_state;
    logic              accept;
    logic              timeout;
    logic              fill_q;
    logic [ADDR_W-1:0] fill_addr_q;

    logic              read_d, write_d, resp_valid_d, resp_err_d;
    logic [ADDR_W-1:0] addr_d;
    logic [LINE_W-1:0] wdata_d, rdata_d;

    // Request handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both 1. req_ready is high only in IDLE; inputs are don't-care after.
    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid & req_ready;

`ifdef MEM_TIMEOUT_EN
    logic [9:0] to_cnt;
    logic       in_bus;

    assign in_bus  = (state == S_WB) || (state == S_RD);
    assign timeout = in_bus && !mem_ready && (to_cnt == TO_LAST);

    // Cleared whenever a bus phase is entered or left, so each phase gets a full budget.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               to_cnt <= '0;
        else if (in_bus && next_state == state) to_cnt <= to_cnt + 10'd1;
        else                                   to_cnt <= '0;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TO_LAST;
    assign timeout            = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_wb)        next_state = S_WB;
                    else if (req_fill) next_state = S_RD;
                    else               next_state = S_DONE;
                end
            end
            S_WB: begin
                if (mem_ready)    next_state = fill_q ? S_GAP : S_DONE;
                else if (timeout) next_state = S_DONE;
            end
            S_GAP:  next_state = S_RD;
            S_RD:   if (mem_ready || timeout) next_state = S_DONE;
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Strobes and response are registered, so they are decoded from next_state.
    always_comb begin
        read_d       = (next_state == S_RD);
        write_d      = (next_state == S_WB);
        resp_valid_d = (next_state == S_DONE);
        resp_err_d   = timeout;
        addr_d       = mem_addr;
        wdata_d      = mem_wdata;
        rdata_d      = resp_rdata;
        if (state == S_IDLE && accept) begin
            if (req_wb) begin
                addr_d  = req_wb_addr;
                wdata_d = req_wdata;
            end else if (req_fill) begin
                addr_d = req_addr;
            end
        end
        if (state == S_GAP) addr_d = fill_addr_q;
        if (state == S_RD && mem_ready) rdata_d = mem_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            mem_read   <= read_d;
            mem_write  <= write_d;
            mem_addr   <= addr_d;
            mem_wdata  <= wdata_d;
            resp_valid <= resp_valid_d;
            resp_err   <= resp_err_d;
            resp_rdata <= rdata_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q      <= 1'b0;
            fill_addr_q <= '0;
        end else if (accept) begin
            fill_q      <= req_fill;
            fill_addr_q <= req_addr;
        end
    end

endmodule

// File: tb/tb_mem_line_master.sv
`timescale 1ns/1ps
// Bench for mem_line_master: request table plus corner sequences against a
// behavioural slow memory with programmable latency.
module tb_mem_line_master;
  localparam int ADDR_W = 28;
  localparam int LINE_W = 128;
  localparam int TO_CYC = 15;

  typedef struct {
    logic              wb;
    logic              fill;
    logic [ADDR_W-1:0] wb_addr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    int                lw;
    int                lr;
    bit                spur;
    int                exp_lat;
    int                exp_wr;
    int                exp_rd;
    logic              exp_err;
  } vec_t;

  typedef struct {
    logic              rv;
    logic              rr;
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
  } cyc_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_wb, req_fill;
  logic [ADDR_W-1:0] req_wb_addr, req_addr, mem_addr;
  logic [LINE_W-1:0] req_wdata, resp_rdata, mem_wdata, mem_rdata;
  logic              resp_valid, resp_err, mem_read, mem_write, mem_ready;

  int total = 0;
  int bad   = 0;

  mem_line_master #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wb(req_wb), .req_fill(req_fill),
    .req_wb_addr(req_wb_addr), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural slow memory ----------------
  logic [LINE_W-1:0] mem_arr [256];
  int                lw_cfg = 1;
  int                lr_cfg = 1;
  bit                spur_en = 1'b0;
  int                st_cnt;

  function automatic logic [LINE_W-1:0] init_word(input int i);
    return {32'hC0DE0000 + 32'(i), 32'h11110000 ^ 32'(i * 7), 32'(i) << 8, ~32'(i)};
  endfunction

  // Ready comes in the Nth strobe-high cycle (latency N); 0 means never.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    st_cnt    = 0;
    for (int i = 0; i < 256; i++) mem_arr[i] = init_word(i);
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (mem_read || mem_write) begin
        st_cnt++;
        if (mem_read && lr_cfg != 0 && st_cnt == lr_cfg) begin
          mem_ready = 1'b1;
          mem_rdata = mem_arr[mem_addr[7:0]];
        end else if (mem_write && lw_cfg != 0 && st_cnt == lw_cfg) begin
          mem_ready = 1'b1;
          mem_arr[mem_addr[7:0]] = mem_wdata;
        end
      end else begin
        st_cnt    = 0;
        mem_ready = spur_en;
      end
    end
  end

  // ---------------- monitor: per-cycle log ----------------
  cyc_t              log_q[$];
  int                acc_q[$];
  int                resp_q[$];
  logic [LINE_W-1:0] rdata_q[$];
  logic              err_q[$];

  always @(negedge clk) begin
    cyc_t c;
    c.rv   = resp_valid;
    c.rr   = req_ready;
    c.rd   = mem_read;
    c.wr   = mem_write;
    c.addr = mem_addr;
    if (req_valid && req_ready) acc_q.push_back(log_q.size());
    if (resp_valid) begin
      resp_q.push_back(log_q.size());
      rdata_q.push_back(resp_rdata);
      err_q.push_back(resp_err);
    end
    log_q.push_back(c);
  end

  // ---------------- scoreboard ----------------
  logic [LINE_W-1:0] exp_q[$];
  logic [LINE_W-1:0] exp_mem [256];
  logic [LINE_W-1:0] last_fill;

  task automatic chk(input string name, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic wait_acc(input int n, input string tag);
    int k = 0;
    while (acc_q.size() < n && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (acc_q.size() < n) begin
      chk({tag, "_accept_timeout"}, 0, 1);
      finish_run();
    end
  endtask

  task automatic wait_resp(input int n, input string tag);
    int k = 0;
    while (resp_q.size() < n && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    if (resp_q.size() < n) begin
      chk({tag, "_resp_timeout"}, 0, 1);
      finish_run();
    end
  endtask

  function automatic vec_t mk(input logic wb, input logic fill, input logic [ADDR_W-1:0] wb_addr,
                              input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] wdata,
                              input int lw, input int lr, input bit spur,
                              input int lat, input int wr, input int rd, input logic err);
    vec_t v;
    v.wb = wb; v.fill = fill; v.wb_addr = wb_addr; v.addr = addr; v.wdata = wdata;
    v.lw = lw; v.lr = lr; v.spur = spur;
    v.exp_lat = lat; v.exp_wr = wr; v.exp_rd = rd; v.exp_err = err;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic scramble_req();
    req_wb      = 1'($urandom);
    req_fill    = 1'($urandom);
    req_wb_addr = ADDR_W'($urandom);
    req_addr    = ADDR_W'($urandom);
    req_wdata   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Latency is counted in cycles from the accepting cycle to the resp_valid cycle, inclusive.
  task automatic run_vec(input vec_t v, input string tag);
    int n_acc, n_resp, a, r, rd_n, wr_n, both_n, addr_bad, busy_rdy, wr_last, rd_first;
    lw_cfg  = v.lw;
    lr_cfg  = v.lr;
    spur_en = v.spur;
    if (v.wb && !v.exp_err) exp_mem[v.wb_addr[7:0]] = v.wdata;
    if (v.fill && !v.exp_err) last_fill = exp_mem[v.addr[7:0]];
    exp_q.push_back(last_fill);
    n_acc  = acc_q.size();
    n_resp = resp_q.size();
    req_wb = v.wb; req_fill = v.fill; req_wb_addr = v.wb_addr; req_addr = v.addr;
    req_wdata = v.wdata; req_valid = 1'b1;
    wait_acc(n_acc + 1, tag);
    req_valid = 1'b0;
    scramble_req();
    wait_resp(n_resp + 1, tag);
    @(posedge clk); #1;
    a = acc_q[n_acc];
    r = resp_q[n_resp];
    rd_n = 0; wr_n = 0; both_n = 0; addr_bad = 0; busy_rdy = 0; wr_last = -1; rd_first = -1;
    for (int i = a + 1; i < r; i++) begin
      if (log_q[i].rd) begin
        rd_n++;
        if (rd_first < 0) rd_first = i;
        if (log_q[i].addr !== v.addr) addr_bad++;
      end
      if (log_q[i].wr) begin
        wr_n++;
        wr_last = i;
        if (log_q[i].addr !== v.wb_addr) addr_bad++;
      end
      if (log_q[i].rd && log_q[i].wr) both_n++;
    end
    for (int i = a + 1; i <= r; i++) if (log_q[i].rr) busy_rdy++;
    chk({tag, "_latency"}, r - a + 1, v.exp_lat);
    chk({tag, "_write_cycles"}, wr_n, v.exp_wr);
    chk({tag, "_read_cycles"}, rd_n, v.exp_rd);
    chk({tag, "_both_strobes"}, both_n, 0);
    chk({tag, "_addr"}, addr_bad, 0);
    chk({tag, "_ready_busy"}, busy_rdy, 0);
    chk({tag, "_single_pulse"}, log_q[r + 1].rv, 0);
    chk({tag, "_rdata"}, rdata_q[n_resp], exp_q.pop_front());
    chk({tag, "_err"}, err_q[n_resp], v.exp_err);
    if (v.wb && v.fill && !v.exp_err) chk({tag, "_gap"}, rd_first - wr_last - 1, 1);
  endtask

  // ---------------- test ----------------
  vec_t tbl[8];
  vec_t rv;

  initial begin
    int n_acc, n_resp, a1, a2, r1, r2, busy_rdy, rd_last1, rd_first2;
    req_valid = 1'b0;
    scramble_req();
    for (int i = 0; i < 256; i++) exp_mem[i] = init_word(i);
    last_fill = '0;

    tbl[0] = mk(1'b0, 1'b1, 28'h0, 28'h0000010, '0, 0, 8, 1'b0, 10, 0, 8, 1'b0);
    tbl[1] = mk(1'b1, 1'b1, 28'h0000020, 28'h0000030, 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF,
                3, 4, 1'b0, 10, 3, 4, 1'b0);
    tbl[2] = mk(1'b1, 1'b0, 28'h0000040, 28'h0, 128'h2222_0000_1111_0000_3333_0000_4444_0000,
                5, 0, 1'b0, 7, 5, 0, 1'b0);
    tbl[3] = mk(1'b0, 1'b0, 28'h0, 28'h0, '0, 0, 0, 1'b0, 2, 0, 0, 1'b0);
    tbl[4] = mk(1'b0, 1'b1, 28'h0, 28'h0000020, '0, 0, 1, 1'b0, 3, 0, 1, 1'b0);
    tbl[5] = mk(1'b1, 1'b1, 28'h0000050, 28'h0000050, 128'h5555_AAAA_5555_AAAA_0F0F_F0F0_1234_5678,
                1, 1, 1'b1, 5, 1, 1, 1'b0);
    tbl[6] = mk(1'b1, 1'b0, 28'h0000060, 28'h0, 128'h6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD,
                1, 0, 1'b0, 3, 1, 0, 1'b0);
    tbl[7] = mk(1'b0, 1'b1, 28'h0, 28'h0000060, '0, 0, 2, 1'b1, 4, 0, 2, 1'b0);

    // Asynchronous reset values, checked before any clock edge.
    rst = 1'b1;
    #2;
    chk("reset_outputs", {mem_read, mem_write, resp_valid, resp_err, mem_addr}, '0);
    chk("reset_wdata", mem_wdata, '0);
    chk("reset_rdata", resp_rdata, '0);
    chk("reset_ready", req_ready, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
      if (i == 1) chk("vec1_mem_written", mem_arr[8'h20], tbl[1].wdata);
    end

    for (int i = 0; i < 4; i++) begin
      rv = mk(1'($urandom), 1'($urandom), 28'h80 + ADDR_W'($urandom_range(0, 15)),
              28'h80 + ADDR_W'($urandom_range(0, 15)), {$urandom, $urandom, $urandom, $urandom},
              $urandom_range(1, 6), $urandom_range(1, 6), 1'($urandom), 0, 0, 0, 1'b0);
      if (rv.wb && rv.fill) rv.exp_lat = rv.lw + rv.lr + 3;
      else if (rv.fill)     rv.exp_lat = rv.lr + 2;
      else if (rv.wb)       rv.exp_lat = rv.lw + 2;
      else                  rv.exp_lat = 2;
      rv.exp_wr = rv.wb ? rv.lw : 0;
      rv.exp_rd = rv.fill ? rv.lr : 0;
      run_vec(rv, $sformatf("rnd%0d", i));
    end

    // Back-to-back fills with req_valid held high.
    lr_cfg = 3; spur_en = 1'b0;
    exp_q.push_back(exp_mem[8'h11]);
    exp_q.push_back(exp_mem[8'h12]);
    last_fill = exp_mem[8'h12];
    n_acc = acc_q.size();
    n_resp = resp_q.size();
    req_wb = 1'b0; req_fill = 1'b1; req_addr = 28'h0000011; req_valid = 1'b1;
    wait_acc(n_acc + 1, "b2b_first");
    req_addr = 28'h0000012;
    wait_acc(n_acc + 2, "b2b_second");
    req_valid = 1'b0;
    wait_resp(n_resp + 2, "b2b");
    a1 = acc_q[n_acc]; a2 = acc_q[n_acc + 1];
    r1 = resp_q[n_resp]; r2 = resp_q[n_resp + 1];
    busy_rdy = 0; rd_last1 = -1; rd_first2 = -1;
    for (int i = a1 + 1; i <= r1; i++) if (log_q[i].rr) busy_rdy++;
    for (int i = a1 + 1; i < r1; i++) if (log_q[i].rd) rd_last1 = i;
    for (int i = r2 - 1; i > a2; i--) if (log_q[i].rd) rd_first2 = i;
    chk("b2b_ready_busy", busy_rdy, 0);
    chk("b2b_second_accept", a2, r1 + 1);
    chk("b2b_low_gap_ge2", (rd_first2 - rd_last1 - 1) >= 2, 1'b1);
    chk("b2b_latency2", r2 - a2 + 1, 5);
    chk("b2b_rdata1", rdata_q[n_resp], exp_q.pop_front());
    chk("b2b_rdata2", rdata_q[n_resp + 1], exp_q.pop_front());

    // Reset in the middle of a read.
    lr_cfg = 30;
    n_acc = acc_q.size();
    n_resp = resp_q.size();
    req_wb = 1'b0; req_fill = 1'b1; req_addr = 28'h0000013; req_valid = 1'b1;
    wait_acc(n_acc + 1, "rst_op");
    req_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("rst_read_before", mem_read, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_read_async", mem_read, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;
    last_fill = '0;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_no_resp", resp_q.size(), n_resp);
    chk("rst_ready", req_ready, 1'b1);
    run_vec(mk(1'b0, 1'b1, 28'h0, 28'h0000014, '0, 0, 3, 1'b0, 5, 0, 3, 1'b0), "post_rst");

`ifdef MEM_TIMEOUT_EN
    run_vec(mk(1'b0, 1'b1, 28'h0, 28'h0000070, '0, 0, 0, 1'b0, TO_CYC + 2, 0, TO_CYC, 1'b1), "to_read");
    run_vec(mk(1'b1, 1'b1, 28'h0000071, 28'h0000072, {4{32'hFACE_FEED}}, 0, 1, 1'b0,
               TO_CYC + 2, TO_CYC, 0, 1'b1), "to_write");
    run_vec(mk(1'b0, 1'b1, 28'h0, 28'h0000072, '0, 0, 2, 1'b0, 4, 0, 2, 1'b0), "to_after");
`endif

    finish_run();
  end
endmodule
